// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the IF/MEM memory-port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_LIM = 4;
  localparam int DEF_TIMEOUT    = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_DM = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arb_wait_timer.sv
// Counts cycles spent waiting on mem_ready; flags when the abort point is reached.
module mem_arb_wait_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] wait_cnt;

  // Wait counter: cleared at grant, advances on each busy cycle without mem_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (enable && !expired) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign expired = (wait_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and data access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_LIM = DEF_STARVE_LIM,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err,
  output logic              pipe_stall
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  arb_state_t state, state_next;
  grant_t     granted;
  logic [SW-1:0] starve_cnt;
  logic if_first;
  logic grant_if, grant_dm;
  logic done, abort;
  logic timer_clear, timer_en, timer_expired;

  mem_arb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  // State register; a reset mid-access simply abandons it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: grant only from IDLE, leave BUSY on completion or abort, RESP lasts one cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (grant_dm) begin
          state_next = BUSY_DM;
        end else if (grant_if) begin
          state_next = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (done || abort) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control decode: DM normally wins, IF wins once it has been passed over STARVE_LIM times.
  always_comb begin
    if_first    = 1'b0;
    grant_if    = 1'b0;
    grant_dm    = 1'b0;
    done        = 1'b0;
    abort       = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if_first    = if_req && (starve_cnt == STARVE_MAX);
        grant_dm    = dm_req && !if_first;
        grant_if    = if_req && !grant_dm;
        timer_clear = grant_dm || grant_if;
      end
      BUSY_IF, BUSY_DM: begin
        done     = mem_ready;
        abort    = !mem_ready && timer_expired;
        timer_en = !mem_ready;
      end
      default: ;
    endcase
  end

  assign granted = grant_dm ? GRANT_DM : GRANT_IF;

  // Starvation counter: counts DM grants that bypass a waiting fetch, saturating at the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm) begin
      if (!if_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Memory-side request: port inputs are latched at grant and held until completion or abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_if || grant_dm) begin
      mem_req <= 1'b1;
      if (granted == GRANT_DM) begin
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else begin
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end
    end else if (done || abort) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
  end

  // Response side: one-cycle ack/err pulses and read data routed to the granted port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      err      <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      err    <= 1'b0;
      if (done || abort) begin
        err <= abort;
        if (state == BUSY_IF) begin
          if_ack <= 1'b1;
          if (done) begin
            if_rdata <= mem_rdata;
          end
        end else begin
          dm_ack <= 1'b1;
          if (done && !mem_we) begin
            dm_rdata <= mem_rdata;
          end
        end
      end
    end
  end

  assign pipe_stall = (if_req && !if_ack) || (dm_req && !dm_ack);

endmodule
